// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: data/opcode widths, the
// five legal ALU opcodes, the FSM state encoding and an opcode legality check.
package alu_pkg;

    localparam int ALU_DATA_W = 64;
    localparam int ALU_OP_W   = 4;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Only the five opcodes above reach the ALU; everything else is flagged.
    function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
        logic legal_s;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR: legal_s = 1'b1;
            default:                                    legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter (combinational).
//   req        in  [1:0]  request vector
//   last_grant in  1      index of the requester served most recently
//   grant      out [1:0]  one-hot grant, all zero when nothing requests
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // A lone requester always wins; on contention the one not served last wins.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters (0: EX-stage issue, 1: branch/aux).
// A granted request is latched, driven to the ALU for one EXEC cycle, and the
// ALU result/flags are returned to the owner as a one-cycle resp_valid pulse.
// Illegal opcodes skip the ALU and answer with err=1 one cycle earlier.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   reqN_valid/ready/a/b/op         request handshake and payload (N=0,1)
//   reqN_resp_valid                 response pulse to the owner
//   reqN_result/zero/great/err      held response of the last op for N
//   alu_a/alu_b/alu_op              to the ALU, zero outside EXEC
//   alu_result/alu_zero/alu_great   from the ALU
//   busy                            high whenever a transaction is in flight
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    output logic              req0_resp_valid,
    output logic [DATA_W-1:0] req0_result,
    output logic              req0_zero,
    output logic              req0_great,
    output logic              req0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              req1_resp_valid,
    output logic [DATA_W-1:0] req1_result,
    output logic              req1_zero,
    output logic              req1_great,
    output logic              req1_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_great,
    output logic              busy
);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [OP_W-1:0]   op_r;
    logic              owner_r;
    logic              last_grant_r;
    logic [1:0]        valid_s;
    logic [1:0]        grant_s;
    logic [1:0]        ready_s;
    logic              accept_s;
    logic              accept_owner_s;
    logic              legal_s;
    logic [DATA_W-1:0] sel_a_s;
    logic [DATA_W-1:0] sel_b_s;
    logic [OP_W-1:0]   sel_op_s;
    logic [DATA_W-1:0] result_r [2];
    logic [1:0]        zero_r;
    logic [1:0]        great_r;
    logic [1:0]        err_r;

    assign valid_s = {req1_valid, req0_valid};

    rr_arbiter_2 u_rr_arbiter (
        .req        (valid_s),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    // Ready only while idle; held low during reset so nothing is accepted then.
    always_comb begin
        ready_s = 2'b00;
        if ((state_r == ST_IDLE) && !reset) begin
            ready_s = grant_s;
        end else begin
            ready_s = 2'b00;
        end
    end

    // The arbiter only grants valid requesters, so any ready bit is an acceptance.
    assign accept_s       = |(ready_s & valid_s);
    assign accept_owner_s = ready_s[1];
    assign req0_ready     = ready_s[0];
    assign req1_ready     = ready_s[1];

    // Payload of the requester being accepted this cycle.
    always_comb begin
        sel_a_s  = req0_a;
        sel_b_s  = req0_b;
        sel_op_s = req0_op;
        if (accept_owner_s) begin
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
            sel_op_s = req1_op;
        end else begin
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
            sel_op_s = req0_op;
        end
    end

    assign legal_s = alu_op_legal(sel_op_s);

    // Next state: legal ops go through EXEC, illegal ones jump straight to RESP.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = legal_s ? ST_EXEC : ST_RESP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register plus operand/opcode/owner latches taken at acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            a_r          <= {DATA_W{1'b0}};
            b_r          <= {DATA_W{1'b0}};
            op_r         <= {OP_W{1'b0}};
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                a_r          <= sel_a_s;
                b_r          <= sel_b_s;
                op_r         <= sel_op_s;
                owner_r      <= accept_owner_s;
                last_grant_r <= accept_owner_s;
            end
        end
    end

    // Per-requester response registers; only the owner's set is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r[0] <= {DATA_W{1'b0}};
            result_r[1] <= {DATA_W{1'b0}};
            zero_r      <= 2'b00;
            great_r     <= 2'b00;
            err_r       <= 2'b00;
        end else if (state_r == ST_EXEC) begin
            result_r[owner_r] <= alu_result;
            zero_r[owner_r]   <= alu_zero;
            great_r[owner_r]  <= alu_great;
            err_r[owner_r]    <= 1'b0;
        end else if (accept_s && !legal_s) begin
            result_r[accept_owner_s] <= {DATA_W{1'b0}};
            zero_r[accept_owner_s]   <= 1'b0;
            great_r[accept_owner_s]  <= 1'b0;
            err_r[accept_owner_s]    <= 1'b1;
        end
    end

    // ALU inputs come from the latches only during EXEC, otherwise quiet.
    always_comb begin
        alu_a  = {DATA_W{1'b0}};
        alu_b  = {DATA_W{1'b0}};
        alu_op = {OP_W{1'b0}};
        if (state_r == ST_EXEC) begin
            alu_a  = a_r;
            alu_b  = b_r;
            alu_op = op_r;
        end else begin
            alu_a  = {DATA_W{1'b0}};
            alu_b  = {DATA_W{1'b0}};
            alu_op = {OP_W{1'b0}};
        end
    end

    assign req0_resp_valid = (state_r == ST_RESP) && !owner_r;
    assign req1_resp_valid = (state_r == ST_RESP) &&  owner_r;
    assign req0_result     = result_r[0];
    assign req0_zero       = zero_r[0];
    assign req0_great      = great_r[0];
    assign req0_err        = err_r[0];
    assign req1_result     = result_r[1];
    assign req1_zero       = zero_r[1];
    assign req1_great      = great_r[1];
    assign req1_err        = err_r[1];
    assign busy            = (state_r != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised + directed bench for alu_share_arbiter with a transaction-level
// reference model and a response scoreboard.
module tb_alu_share_arbiter;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  op;
    } req_t;

    typedef struct {
        int          owner;
        logic [63:0] result;
        logic        zero;
        logic        great;
        logic        err;
        int          due;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_resp_valid, req0_zero, req0_great, req0_err;
    logic        req1_valid, req1_ready, req1_resp_valid, req1_zero, req1_great, req1_err;
    logic [63:0] req0_a, req0_b, req0_result, req1_a, req1_b, req1_result;
    logic [3:0]  req0_op, req1_op, alu_op;
    logic [63:0] alu_a, alu_b, alu_result;
    logic        alu_zero, alu_great, busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference-model state (value holds for the cycle after the next edge).
    int   m_state = 0;       // 0 idle, 1 executing, 2 responding
    int   m_last = 1;
    int   m_owner = 0;
    req_t m_cur = '0;
    rsp_t m_rsp;
    rsp_t held [2];
    bit   flush_req = 1'b0;
    bit   acc [2];
    bit   en [2];
    req_t src_q [2][$];
    rsp_t exp_q [$];
    int   grant_log [$];
    int   acc_cyc_log [$];

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_resp_valid(req0_resp_valid), .req0_result(req0_result),
        .req0_zero(req0_zero), .req0_great(req0_great), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_resp_valid(req1_resp_valid), .req1_result(req1_result),
        .req1_zero(req1_zero), .req1_great(req1_great), .req1_err(req1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_great(alu_great), .busy(busy)
    );

    // The external ALU the arbiter talks to.
    function automatic logic [63:0] env_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b1100: return ~(a | b);
            default: return 64'd0;
        endcase
    endfunction

    assign alu_result = env_alu(alu_op, alu_a, alu_b);
    assign alu_zero   = (alu_result == 64'd0);
    assign alu_great  = (alu_result != 64'd0);

    // Expected response of a request, straight from the opcode table.
    function automatic rsp_t ref_resp(input int owner, input req_t r);
        rsp_t x;
        x.owner = owner;
        x.err   = 1'b0;
        x.due   = 0;
        case (r.op)
            4'b0000: x.result = r.a & r.b;
            4'b0001: x.result = r.a | r.b;
            4'b0010: x.result = r.a + r.b;
            4'b0110: x.result = r.a - r.b;
            4'b1100: x.result = ~(r.a | r.b);
            default: begin x.result = 64'd0; x.err = 1'b1; end
        endcase
        x.zero  = !x.err && (x.result == 64'd0);
        x.great = !x.err && (x.result != 64'd0);
        return x;
    endfunction

    function automatic rsp_t zero_rsp();
        rsp_t x;
        x.owner = 0; x.result = 64'd0; x.zero = 1'b0; x.great = 1'b0; x.err = 1'b0; x.due = 0;
        return x;
    endfunction

    function automatic logic [127:0] pack_out(input logic [63:0] r, input logic z, input logic g, input logic e);
        return {61'd0, r, z, g, e};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Cycle count and scoreboard flush when the edge applies reset.
    always @(posedge clk) begin
        cyc++;
        if (flush_req) begin
            exp_q.delete();
            flush_req = 1'b0;
        end
    end

    // Reference model: compare this cycle, then advance to the next one.
    always @(negedge clk) begin
        logic [1:0] v;
        logic [1:0] exp_ready;
        int o;
        rsp_t r;
        v = {req1_valid, req0_valid};
        exp_ready = 2'b00;
        o = 0;
        if (m_state == 0 && !reset && v != 2'b00) begin
            if (v == 2'b11) o = 1 - m_last;
            else o = v[1] ? 1 : 0;
            exp_ready[o] = 1'b1;
        end
        check("ready", {126'd0, req1_ready, req0_ready}, {126'd0, exp_ready});
        check("busy", {127'd0, busy}, {127'd0, (m_state != 0)});
        if (m_state == 1) begin
            check("alu_drive", {alu_a, alu_b}, {m_cur.a, m_cur.b});
            check("alu_op", {124'd0, alu_op}, {124'd0, m_cur.op});
        end else begin
            check("alu_quiet", {60'd0, alu_op, alu_a | alu_b}, 128'd0);
        end
        check("held0", pack_out(req0_result, req0_zero, req0_great, req0_err),
              pack_out(held[0].result, held[0].zero, held[0].great, held[0].err));
        check("held1", pack_out(req1_result, req1_zero, req1_great, req1_err),
              pack_out(held[1].result, held[1].zero, held[1].great, held[1].err));

        if (reset) begin
            m_state = 0;
            m_last = 1;
            held[0] = zero_rsp();
            held[1] = zero_rsp();
            flush_req = 1'b1;
        end else if (m_state == 0) begin
            if (exp_ready != 2'b00) begin
                m_cur = src_q[o][0];
                r = ref_resp(o, m_cur);
                r.due = cyc + (r.err ? 1 : 2);
                exp_q.push_back(r);
                acc[o] = 1'b1;
                m_last = o;
                m_owner = o;
                grant_log.push_back(o);
                acc_cyc_log.push_back(cyc);
                if (r.err) begin
                    held[o] = r;
                    m_state = 2;
                end else begin
                    m_rsp = r;
                    m_state = 1;
                end
            end
        end else if (m_state == 1) begin
            held[m_owner] = m_rsp;
            m_state = 2;
        end else begin
            m_state = 0;
        end
    end

    // Response monitor: every pulse must match the oldest expected response.
    always @(negedge clk) begin
        rsp_t r;
        if (req0_resp_valid || req1_resp_valid) begin
            if (exp_q.size() == 0) begin
                fail_now("resp_unexpected", $sformatf("actual resp_valid=%b%b required none",
                         req1_resp_valid, req0_resp_valid));
            end else begin
                r = exp_q.pop_front();
                check("resp_owner", {126'd0, req1_resp_valid, req0_resp_valid},
                      (r.owner == 1) ? 128'd2 : 128'd1);
                check("resp_cycle", 128'(cyc), 128'(r.due));
                if (r.owner == 1)
                    check("resp1_data", pack_out(req1_result, req1_zero, req1_great, req1_err),
                          pack_out(r.result, r.zero, r.great, r.err));
                else
                    check("resp0_data", pack_out(req0_result, req0_zero, req0_great, req0_err),
                          pack_out(r.result, r.zero, r.great, r.err));
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            r = exp_q.pop_front();
            fail_now("resp_missing", $sformatf("actual no pulse required pulse to req%0d", r.owner));
        end
    end

    // Retire accepted items and present the current head of each source.
    task automatic drive();
        req_t h;
        for (int n = 0; n < 2; n++) begin
            if (acc[n]) begin
                void'(src_q[n].pop_front());
                acc[n] = 1'b0;
            end
        end
        if (en[0] && src_q[0].size() > 0) begin
            h = src_q[0][0];
            req0_valid = 1'b1; req0_a = h.a; req0_b = h.b; req0_op = h.op;
        end else begin
            req0_valid = 1'b0;
        end
        if (en[1] && src_q[1].size() > 0) begin
            h = src_q[1][0];
            req1_valid = 1'b1; req1_a = h.a; req1_b = h.b; req1_op = h.op;
        end else begin
            req1_valid = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic push(input int n, input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
        req_t r;
        r.a = a; r.b = b; r.op = op;
        src_q[n].push_back(r);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(src_q[0].size() == 0 && src_q[1].size() == 0 && m_state == 0 &&
                     exp_q.size() == 0) && k < budget);
        if (k >= budget) fail_now("idle_timeout", $sformatf("still busy after %0d cycles", budget));
    endtask

    task automatic wait_exec(input int budget);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (m_state != 1 && k < budget);
        if (m_state != 1) fail_now("exec_timeout", "no EXEC cycle reached");
    endtask

    function automatic logic [3:0] rand_op();
        case ($urandom_range(0, 6))
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0010;
            3: return 4'b0110;
            4: return 4'b1100;
            default: return 4'($urandom);
        endcase
    endfunction

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        int acks1;
        held[0] = zero_rsp();
        held[1] = zero_rsp();
        acc[0] = 1'b0; acc[1] = 1'b0;
        en[0] = 1'b1; en[1] = 1'b1;
        reset = 1'b1;
        req0_valid = 1'b0; req0_a = 64'd0; req0_b = 64'd0; req0_op = 4'd0;
        req1_valid = 1'b0; req1_a = 64'd0; req1_b = 64'd0; req1_op = 4'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Single ADD from req0, then SUB with equal operands from req1.
        push(0, 64'd5, 64'd7, 4'b0010);
        wait_idle(20);
        check("add_result", pack_out(req0_result, req0_zero, req0_great, req0_err),
              pack_out(64'd12, 1'b0, 1'b1, 1'b0));
        push(1, 64'd9, 64'd9, 4'b0110);
        wait_idle(20);
        check("sub_result", pack_out(req1_result, req1_zero, req1_great, req1_err),
              pack_out(64'd0, 1'b1, 1'b0, 1'b0));
        check("req0_kept", {64'd0, req0_result}, 128'd12);

        // Illegal opcode, then a legal op clears err.
        push(0, 64'd1, 64'd2, 4'b0111);
        wait_idle(20);
        check("illegal_err", pack_out(req0_result, req0_zero, req0_great, req0_err),
              pack_out(64'd0, 1'b0, 1'b0, 1'b1));
        push(0, 64'd3, 64'd4, 4'b0001);
        wait_idle(20);
        check("err_cleared", pack_out(req0_result, req0_zero, req0_great, req0_err),
              pack_out(64'd7, 1'b0, 1'b1, 1'b0));

        // Reset held for two cycles in the middle of EXEC.
        push(0, 64'd100, 64'd23, 4'b0010);
        wait_exec(10);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("reset_outs", {busy, req0_ready, req1_ready, alu_op, req0_result, 59'd0},
              128'd0);
        check("reset_held", pack_out(req0_result | req1_result, req0_zero | req1_zero,
              req0_great | req1_great, req0_err | req1_err), 128'd0);

        // Both requesters held valid straight out of reset.
        grant_log.delete();
        acc_cyc_log.delete();
        for (int i = 0; i < 2; i++) begin
            push(0, 64'($urandom), 64'($urandom), 4'b0010);
            push(1, 64'($urandom), 64'($urandom), 4'b0001);
        end
        drive();
        wait_idle(40);
        check("grant_count", 128'(grant_log.size()), 128'd4);
        if (grant_log.size() == 4) begin
            check("grant_order", {124'd0, grant_log[3][0], grant_log[2][0], grant_log[1][0],
                  grant_log[0][0]}, 128'b1010);
            for (int i = 1; i < 4; i++)
                check("grant_spacing", 128'(acc_cyc_log[i] - acc_cyc_log[i-1]), 128'd3);
        end

        // req1 valid only while req0 is busy, dropped before it could win.
        push(0, 64'd11, 64'd22, 4'b1100);
        wait_exec(10);
        acks1 = 0;
        foreach (grant_log[i]) if (grant_log[i] == 1) acks1++;
        push(1, 64'd1, 64'd1, 4'b0010);
        drive();
        tick();
        src_q[1].delete();
        drive();
        wait_idle(20);
        foreach (grant_log[i]) if (grant_log[i] == 1) acks1--;
        check("dropped_req1", 128'(acks1), 128'd0);

        // Random traffic with valid toggling.
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (src_q[n].size() < 2 && $urandom_range(0, 3) == 0) begin
                    ra = {$urandom, $urandom};
                    rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
                    push(n, ra, rb, rand_op());
                end
                if ($urandom_range(0, 9) == 0) en[n] = !en[n];
            end
            tick();
        end
        en[0] = 1'b1;
        en[1] = 1'b1;
        drive();
        wait_idle(200);
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
